// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out shifter with a one-word holding
// register. Words arrive over a valid/ready handshake and leave one bit per
// clock over a valid/ready serial stream. The holding register lets the next
// word be handed over while the current one is still shifting, so a stream
// with continuous downstream readiness has no bubbles between words.
module piso_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic                  dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_last
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);

    // ST_SHIFT means the shifter holds a word whose current bit is on dout.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
    logic [CW-1:0]         count, count_nxt;
    logic [DATA_WIDTH-1:0] hold, hold_nxt;
    logic                  hold_valid, hold_valid_nxt;

    logic                  accept;
    logic                  transfer;
    logic                  free;
    logic                  out_bit;
    logic [DATA_WIDTH-1:0] shreg_shifted;

    // Ready depends only on the holding register, so it never loops back
    // through din_valid; it is forced low while reset is asserted.
    assign din_ready  = resetn & ~hold_valid;
    assign dout_valid = (state == ST_SHIFT);
    assign out_bit    = MSB_FIRST ? shreg[DATA_WIDTH-1] : shreg[0];
    assign dout       = dout_valid & out_bit;
    assign dout_last  = dout_valid & (count == LAST_IDX);

    assign accept   = din_valid & din_ready;
    assign transfer = dout_valid & dout_ready;
    // The shifter can take a new word when empty, or when its final bit is
    // leaving on this edge.
    assign free     = ~dout_valid | (transfer & dout_last);

    // Move the next bit to the output end of the shifter.
    always_comb begin
        shreg_shifted = shreg;
        if (MSB_FIRST) begin
            shreg_shifted = {shreg[DATA_WIDTH-2:0], 1'b0};
        end else begin
            shreg_shifted = {1'b0, shreg[DATA_WIDTH-1:1]};
        end
    end

    // Next-state: reload the shifter when free (held word first), otherwise
    // shift on transfer and park an incoming word in the holding register.
    always_comb begin
        state_nxt      = state;
        shreg_nxt      = shreg;
        count_nxt      = count;
        hold_nxt       = hold;
        hold_valid_nxt = hold_valid;

        if (free) begin
            if (hold_valid) begin
                shreg_nxt = hold;
                count_nxt = '0;
                state_nxt = ST_SHIFT;
                if (accept) begin
                    hold_nxt = din;
                end else begin
                    hold_valid_nxt = 1'b0;
                end
            end else if (accept) begin
                shreg_nxt = din;
                count_nxt = '0;
                state_nxt = ST_SHIFT;
            end else begin
                state_nxt = ST_IDLE;
            end
        end else begin
            if (transfer) begin
                shreg_nxt = shreg_shifted;
                count_nxt = count + CW'(1);
            end
            if (accept) begin
                hold_nxt       = din;
                hold_valid_nxt = 1'b1;
            end
        end
    end

    // State register; reset discards both the partial and the held word.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            count      <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            count      <= count_nxt;
            hold       <= hold_nxt;
            hold_valid <= hold_valid_nxt;
        end
    end

endmodule
